sram_rr_arbiter: RTL and testbench

//  Shares one synchronous single-port SRAM macro (14-bit word address, 32-bit data, per-byte

---
 rtl/sram_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rr_arbiter.sv
// Burst arbiter sharing one single-port SRAM macro between NREQ requesters (round-robin).
// Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (req 0 highest) instead of round-robin.
module sram_rr_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_we,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*LEN_W-1:0]      req_len,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*(DATA_W/8)-1:0] req_wstrb,
    output logic [NREQ-1:0]            req_ready,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [ADDR_W-1:0]          sram_A,
    output logic [DATA_W-1:0]          sram_DI,
    output logic [DATA_W/8-1:0]        sram_WEB,
    input  logic [DATA_W-1:0]          sram_DO,
    output logic                       busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  winner;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic              accept;
    logic [NREQ-1:0]   rsp_vld_p1;
    logic [DATA_W-1:0] rsp_hold;

    function automatic logic [IDX_W-1:0] pick_winner(input logic [NREQ-1:0]  v,
                                                     input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) pick = IDX_W'(i);
        end
`else
        logic found;
        int   c;
        pick  = '0;
        found = 1'b0;
        c     = 0;
        // scan starts just after the previous owner so every requester gets a turn
        for (int j = 1; j <= NREQ; j++) begin
            c = int'(last) + j;
            if (c >= NREQ) c = c - NREQ;
            if (!found && v[c[IDX_W-1:0]]) begin
                pick  = c[IDX_W-1:0];
                found = 1'b1;
            end
        end
`endif
        return pick;
    endfunction

    always_comb begin
        winner    = pick_winner(req_valid, last_grant);
        busy      = (state == S_BURST);
        req_ready = busy ? (NREQ'(1) << owner) : '0;
        accept    = busy && req_valid[owner];
        sram_A    = '0;
        sram_DI   = '0;
        sram_WEB  = '1;
        if (accept) begin
            sram_A = base_q + ADDR_W'(beat_cnt);
            if (we_q) begin
                sram_DI  = req_wdata[owner*DATA_W +: DATA_W];
                sram_WEB = ~req_wstrb[owner*STRB_W +: STRB_W];
            end
        end
        rsp_valid = rsp_vld_p1;
        rsp_data  = (|rsp_vld_p1) ? sram_DO : rsp_hold;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_grant <= IDX_W'(NREQ - 1);
            we_q       <= 1'b0;
            beat_cnt   <= '0;
            rsp_vld_p1 <= '0;
            rsp_hold   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        state    <= S_BURST;
                        owner    <= winner;
                        we_q     <= req_we[winner];
                        beat_cnt <= '0;
                    end
                end
                S_BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + LEN_W'(1);
                        if (beat_cnt == len_q) begin
                            state      <= S_IDLE;
                            last_grant <= owner;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            // stage p1: SRAM read data appears one cycle after the accepted address
            rsp_vld_p1 <= (accept && !we_q) ? req_ready : '0;
            if (|rsp_vld_p1) rsp_hold <= sram_DO;
        end
    end

    always_ff @(posedge ACLK) begin
        if (state == S_IDLE && (|req_valid)) begin
            base_q <= req_addr[winner*ADDR_W +: ADDR_W];
            len_q  <= req_len[winner*LEN_W +: LEN_W];
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter: cycle scoreboard model plus directed literal checks.
module tb_sram_rr_arbiter;

    localparam int NREQ = 2;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [27:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [13:0] sram_A;
    logic [31:0] sram_DI;
    logic [3:0]  sram_WEB;
    logic [31:0] sram_DO;
    logic        busy;

    always #5 ACLK = ~ACLK;

    sram_rr_arbiter #(.NREQ(2), .ADDR_W(14), .DATA_W(32), .LEN_W(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_A(sram_A), .sram_DI(sram_DI), .sram_WEB(sram_WEB), .sram_DO(sram_DO),
        .busy(busy)
    );

    // SRAM macro model and the bench's own reference copy of its contents
    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];

    always @(posedge ACLK) begin
        for (int b = 0; b < 4; b++)
            if (sram_WEB[b] == 1'b0) mem[sram_A][8*b +: 8] <= sram_DI[8*b +: 8];
        sram_DO <= mem[sram_A];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input int last);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    // transaction-level model: who owns the SRAM, which beat is next, what read data is owed
    int          m_own = -1;
    int          m_last = NREQ - 1;
    int          m_base = 0;
    int          m_len = 0;
    int          m_cnt = 0;
    bit          m_we = 0;
    bit          m_pend = 0;
    int          m_pown = 0;
    logic [31:0] m_pdata = '0;
    logic [31:0] m_hold = '0;

    always @(negedge ACLK) begin : model
        logic [1:0]  e_ready, e_rv;
        logic [13:0] e_a;
        logic [31:0] e_di, e_rd;
        logic [3:0]  e_web;
        bit          acc;
        int          addr, w;
        acc     = (m_own >= 0) ? req_valid[m_own] : 1'b0;
        addr    = (m_base + m_cnt) % 16384;
        e_ready = (m_own >= 0) ? (2'b01 << m_own) : 2'b00;
        e_a     = acc ? addr[13:0] : 14'h0;
        e_di    = (acc && m_we) ? req_wdata[m_own*32 +: 32] : 32'h0;
        e_web   = (acc && m_we) ? ~req_wstrb[m_own*4 +: 4] : 4'hF;
        e_rv    = m_pend ? (2'b01 << m_pown) : 2'b00;
        e_rd    = m_pend ? m_pdata : m_hold;
        chk("busy", busy, m_own >= 0);
        chk("req_ready", req_ready, e_ready);
        chk("sram_A", sram_A, e_a);
        chk("sram_DI", sram_DI, e_di);
        chk("sram_WEB", sram_WEB, e_web);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        if (ARESET) begin
            m_own = -1; m_last = NREQ - 1; m_pend = 0; m_hold = '0;
        end else begin
            if (m_pend) m_hold = m_pdata;
            m_pend = acc && !m_we;
            if (acc && !m_we) begin
                m_pown  = m_own;
                m_pdata = ref_mem[addr];
            end
            if (acc && m_we)
                for (int b = 0; b < 4; b++)
                    if (req_wstrb[m_own*4 + b]) ref_mem[addr][8*b +: 8] = req_wdata[m_own*32 + 8*b +: 8];
            if (m_own < 0) begin
                w = pick(req_valid, m_last);
                if (w >= 0) begin
                    m_own  = w;
                    m_we   = req_we[w];
                    m_base = int'(req_addr[w*14 +: 14]);
                    m_len  = int'(req_len[w*4 +: 4]);
                    m_cnt  = 0;
                end
            end else if (acc) begin
                if (m_cnt == m_len) begin
                    m_last = m_own;
                    m_own  = -1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // observed accepts and responses, for the directed literal checks
    int          acc_own [$];
    logic [13:0] acc_addr[$];
    logic [3:0]  acc_web [$];
    logic [31:0] rsp_q   [$];

    always @(negedge ACLK) begin
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) begin
                acc_own.push_back(i);
                acc_addr.push_back(sram_A);
                acc_web.push_back(sram_WEB);
            end
        if (|rsp_valid) rsp_q.push_back(rsp_data);
    end

    task automatic clear_obs();
        acc_own.delete(); acc_addr.delete(); acc_web.delete(); rsp_q.delete();
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_burst(input int i, input bit we, input logic [13:0] addr, input logic [3:0] len,
                            input logic [31:0] wd0, input logic [31:0] wd1, input logic [3:0] strb,
                            input int stall_at);
        int beats, guard;
        bit stalled;
        beats = 0; guard = 0; stalled = 0;
        req_we[i] = we;
        req_addr[i*14 +: 14] = addr;
        req_len[i*4 +: 4] = len;
        req_wdata[i*32 +: 32] = wd0;
        req_wstrb[i*4 +: 4] = strb;
        req_valid[i] = 1'b1;
        while (beats <= int'(len) && guard < 300) begin
            @(negedge ACLK);
            guard++;
            if (req_ready[i] && req_valid[i]) beats++;
            tick();
            if (beats > 0) req_wdata[i*32 +: 32] = wd1;
            if (beats == stall_at && !stalled) begin
                stalled = 1;
                req_valid[i] = 1'b0;
                repeat (5) @(posedge ACLK);
                #1;
                req_valid[i] = 1'b1;
            end
        end
        req_valid[i] = 1'b0;
        chk("burst_completes", guard < 300, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation time exceeded 300000");
        $fatal(1);
    end

    initial begin
        int g;
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = {16'hBEEF, i[15:0]};
            ref_mem[i] = {16'hBEEF, i[15:0]};
        end
        repeat (2) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_sram_A", sram_A, 14'h0);
        chk("rst_sram_DI", sram_DI, 32'h0);
        chk("rst_sram_WEB", sram_WEB, 4'hF);
        ARESET = 1'b0;
        tick();

        // read burst of 4 from 0x10
        clear_obs();
        do_burst(0, 1'b0, 14'h0010, 4'd3, 32'h0, 32'h0, 4'h0, -1);
        repeat (3) tick();
        chk("t1_naccepts", acc_addr.size(), 4);
        chk("t1_nrsp", rsp_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("t1_addr", acc_addr[k], 14'h0010 + 14'(k));
            chk("t1_data", rsp_q[k], 32'hBEEF0010 + 32'(k));
        end

        // contention from reset, single-beat bursts
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        clear_obs();
        req_we = 2'b00;
        req_len = 8'h00;
        req_addr = {14'h0200, 14'h0100};
        req_valid = 2'b11;
        repeat (8) tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("t2_naccepts", acc_own.size(), 4);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) chk("t2_owner", acc_own[k], 0);
`else
        chk("t2_owner0", acc_own[0], 0);
        chk("t2_owner1", acc_own[1], 1);
        chk("t2_owner2", acc_own[2], 0);
        chk("t2_owner3", acc_own[3], 1);
        chk("t2_data1", rsp_q[1], 32'hBEEF0200);
`endif
        chk("t2_data0", rsp_q[0], 32'hBEEF0100);

        // write with strobes wrapping the top of the address space, then read back
        clear_obs();
        do_burst(1, 1'b1, 14'h3FFF, 4'd1, 32'h11223344, 32'h55667788, 4'b0101, -1);
        repeat (2) tick();
        chk("t3_addr0", acc_addr[0], 14'h3FFF);
        chk("t3_addr1", acc_addr[1], 14'h0000);
        chk("t3_web0", acc_web[0], 4'b1010);
        chk("t3_web1", acc_web[1], 4'b1010);
        clear_obs();
        do_burst(0, 1'b0, 14'h3FFF, 4'd1, 32'h0, 32'h0, 4'h0, -1);
        repeat (3) tick();
        chk("t3_read0", rsp_q[0], 32'hBE223F44);
        chk("t3_read1", rsp_q[1], 32'hBE660088);

        // owner stalls mid-burst while the other requester waits
        clear_obs();
        fork
            do_burst(1, 1'b0, 14'h0020, 4'd3, 32'h0, 32'h0, 4'h0, 2);
            begin
                tick();
                do_burst(0, 1'b0, 14'h0040, 4'd0, 32'h0, 32'h0, 4'h0, -1);
            end
        join
        repeat (3) tick();
        chk("t4_naccepts", acc_own.size(), 5);
        for (int k = 0; k < 4; k++) begin
            chk("t4_owner", acc_own[k], 1);
            chk("t4_addr", acc_addr[k], 14'h0020 + 14'(k));
        end
        chk("t4_last_owner", acc_own[4], 0);
        chk("t4_last_addr", acc_addr[4], 14'h0040);

        // reset at beat 2 of an 8-beat read
        clear_obs();
        req_we[0] = 1'b0;
        req_addr[13:0] = 14'h0080;
        req_len[3:0] = 4'd7;
        req_valid[0] = 1'b1;
        g = 0;
        while (acc_own.size() < 2 && g < 50) begin
            tick();
            g++;
        end
        chk("t5_reached_beat2", g < 50, 1'b1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        req_valid = 2'b00;
        repeat (4) tick();
        chk("t5_nrsp", rsp_q.size(), 2);
        chk("t5_busy", busy, 1'b0);
        clear_obs();
        req_len = 8'h00;
        req_addr = {14'h0300, 14'h0301};
        req_valid = 2'b11;
        repeat (2) tick();
        req_valid = 2'b00;
        repeat (2) tick();
        chk("t5_ngrants", acc_own.size(), 1);
        chk("t5_first_grant", acc_own[0], 0);

        // both requesters held valid continuously
        clear_obs();
        req_valid = 2'b11;
        repeat (8) tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("t6_naccepts", acc_own.size(), 4);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) chk("t6_owner", acc_own[k], 0);
`else
        for (int k = 0; k < 4; k++) chk("t6_owner", acc_own[k], (k % 2 == 0) ? 1 : 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
